uart_rx_bit_timer: RTL and testbench
====================================

# uart_rx_bit_timer

Parametrised bit-timing engine for the UART receiver. It counts oversampling clocks within each bit and bits within each frame, and emits three mid-bit sample strobes for majority-vote sampling, plus bit-done and frame-done pulses. It takes its frame format (data length, parity, 1/2 stop bits) from configuration inputs, not a fixed count. It sits between the RX FSM (which drives `enable`) and the data sampler, deserializer, parity check and stop check.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`; max oversampling = 2^PRESCALE_W − 1.
- `MAX_DATA_BITS`, 9: largest legal data length; legal range 5..11 so frame length fits 4 bits.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  counting enable from RX FSM; low = idle/clear.
- `prescale`  in  PRESCALE_W  clocks per bit.
- `data_bits`  in  4  data bits per frame.
- `par_en`  in  1  parity bit present.
- `stop2`  in  1  two stop bits when high.
- `edge_cnt`  out  PRESCALE_W  position within current bit, 0..p−1.
- `bit_cnt`  out  4  bit index within frame; 0 = start bit.
- `busy`  out  1  frame in progress (config latched).
- `sample_strb`  out  1  sample-point strobe.
- `sample_idx`  out  2  which strobe: 0, 1, 2.
- `bit_done`  out  1  last clock of current bit.
- `frame_done`  out  1  last clock of last bit of frame.

## Operation
- Clamping: effective prescale p = max(prescale, 4). Effective data length d = data_bits clamped to 5..MAX_DATA_BITS.
- Frame length: L = 1 + d + par_en + 1 + stop2. Computed in 4 bits; no overflow within legal parameters.
- Config source:
  - While busy=0, p and L come from live inputs.
  - At the clock edge where enable=1 and busy=0, p and L are latched into internal registers and busy←1.
  - While busy=1, latched values are used. Input changes mid-frame are ignored.
- Edge counter: when enable=1, edge_cnt increments each clock and wraps to 0 when edge_cnt = p−1.
- Bit counter: bit_cnt increments on that wrap.
- Strobes and pulses are combinational decodes of registered state, gated by enable:
  - Let m = p >> 1. sample_strb=1 when edge_cnt ∈ {m−1, m, m+1}. sample_idx = 0, 1, 2 respectively; sample_idx = 0 otherwise.
  - bit_done = enable & (edge_cnt == p−1).
  - frame_done = bit_done & (bit_cnt == L−1).
- Frame end: on the edge after frame_done, edge_cnt←0, bit_cnt←0, busy←0.
  - If enable is still high, the next cycle is edge 0 of a new frame: config is re-latched and there are no gap cycles.
- Disable: enable=0 clears edge_cnt, bit_cnt and busy at the next edge. All pulses are 0 while enable=0.
- Abort: deasserting enable mid-frame is a legal abort. No frame_done is issued.

## Timing
- Reset (async, rst=1): edge_cnt=0, bit_cnt=0, busy=0, latched p=4, latched L=0. All pulse outputs read 0 because enable gating is assumed low. The block resumes on the first clock edge after rst falls.
- The first enabled cycle is edge 0 of bit 0. Zero latency from enable to counting.
- bit_done occurs exactly every p clocks, on cycles p−1, 2p−1, …
- frame_done occurs on enabled cycle L·p − 1, counted from the first enabled cycle.
- p=4: strobes at edges 1, 2, 3. The third strobe coincides with bit_done; both assert the same cycle.
- Odd p: m = floor(p/2). Example: p=5 gives strobes at 1, 2, 3.
- Max p (2^PRESCALE_W − 1): edge_cnt reaches p−1 with no overflow.
- Reset asserted mid-frame: all registers clear immediately. No pulse may be output while rst=1.

## Test plan
- Base frame: p=8, data_bits=8, par_en=0, stop2=0, enable held high.
  - Expect L=10.
  - Strobes at edges 3/4/5 with idx 0/1/2.
  - bit_done every 8 clocks.
  - frame_done on cycle 79; edge_cnt and bit_cnt = 0 on cycle 80.
- Max format: p=16, data_bits=9, par_en=1, stop2=1 → L=13. Expect frame_done on cycle 207, strobes at 7/8/9.
- Clamps:
  - prescale=2 → behaves as p=4: bit_done every 4 clocks, strobes 1/2/3.
  - data_bits=15 → d=MAX_DATA_BITS (9), L=11 with par_en=0, stop2=0.
  - data_bits=2 → d=5, L=7.
- Mid-frame config change: start with p=8; change prescale to 12 and data_bits to 5 at cycle 20. Timing must remain p=8, L=10.
- Back-to-back frames and abort:
  - Keep enable high across frame_done. The second frame starts with no idle cycle and latches new config.
  - Drop enable at cycle 30. busy=0 and counters=0 next cycle; no frame_done.
- Async reset: assert rst between clock edges at cycle 45. All outputs go 0 immediately; counting restarts from edge 0 when rst falls with enable=1.

Source files
------------

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: bit-timing engine for the UART receiver.
// Counts oversampling clocks within a bit and bits within a frame, and emits
// three mid-bit sample strobes plus bit-done / frame-done pulses.
// Ports:
//   clk, rst         - rising-edge clock, async active-high reset
//   enable           - counting enable from the RX FSM (low = idle/clear)
//   prescale         - clocks per bit (clamped to >= 4)
//   data_bits        - data bits per frame (clamped to 5..MAX_DATA_BITS)
//   par_en, stop2    - parity bit present, two stop bits
//   edge_cnt         - position within the current bit
//   bit_cnt          - bit index within the frame (0 = start bit)
//   busy             - frame in progress, configuration latched
//   sample_strb/idx  - sample-point strobe and which of the three it is
//   bit_done         - last clock of the current bit
//   frame_done       - last clock of the last bit of the frame
module uart_rx_bit_timer #(
  parameter int unsigned PRESCALE_W    = 6,
  parameter int unsigned MAX_DATA_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_bits,
  input  logic                  par_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  busy,
  output logic                  sample_strb,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = 4;
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [CNT_W-1:0]      D_MIN = CNT_W'(5);
  localparam logic [CNT_W-1:0]      D_MAX = CNT_W'(MAX_DATA_BITS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_q, edge_d;
  logic [CNT_W-1:0]        bit_q, bit_d;
  logic [PRESCALE_W-1:0]   p_lat_q, p_lat_d;
  logic [CNT_W-1:0]        len_lat_q, len_lat_d;

  logic [PRESCALE_W-1:0]   p_live, p_eff, p_last, mid;
  logic [CNT_W-1:0]        d_live, len_live, len_eff, len_last;
  logic                    wrap, last_bit, active;

  // Clamp the live configuration and pick live vs. latched values
  always_comb begin
    p_live = (prescale < P_MIN) ? P_MIN : prescale;
    if (data_bits < D_MIN) begin
      d_live = D_MIN;
    end else if (data_bits > D_MAX) begin
      d_live = D_MAX;
    end else begin
      d_live = data_bits;
    end
    // start + data + parity + stop (+ second stop)
    len_live = CNT_W'(2) + d_live + CNT_W'(par_en) + CNT_W'(stop2);
    p_eff    = (state_q == S_RUN) ? p_lat_q   : p_live;
    len_eff  = (state_q == S_RUN) ? len_lat_q : len_live;
    p_last   = p_eff - PRESCALE_W'(1);
    len_last = len_eff - CNT_W'(1);
    mid      = p_eff >> 1;
    wrap     = (edge_q == p_last);
    last_bit = (bit_q == len_last);
  end

  // Pulse decode; rst is included so nothing fires while reset is held
  always_comb begin
    active      = enable & ~rst;
    bit_done    = active & wrap;
    frame_done  = active & wrap & last_bit;
    sample_strb = 1'b0;
    sample_idx  = 2'd0;
    if (active) begin
      if (edge_q == mid - PRESCALE_W'(1)) begin
        sample_strb = 1'b1;
        sample_idx  = 2'd0;
      end else if (edge_q == mid) begin
        sample_strb = 1'b1;
        sample_idx  = 2'd1;
      end else if (edge_q == mid + PRESCALE_W'(1)) begin
        sample_strb = 1'b1;
        sample_idx  = 2'd2;
      end
    end
  end

  // Next-state: latch config on frame start, count edges and bits
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    p_lat_d   = p_lat_q;
    len_lat_d = len_lat_q;
    if (!enable) begin
      state_d = S_IDLE;
      edge_d  = '0;
      bit_d   = '0;
    end else begin
      if (state_q == S_IDLE) begin
        state_d   = S_RUN;
        p_lat_d   = p_live;
        len_lat_d = len_live;
      end
      if (wrap) begin
        edge_d = '0;
        if (last_bit) begin
          // frame end: drop busy so the next cycle re-latches config
          bit_d   = '0;
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + CNT_W'(1);
        end
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      p_lat_q   <= P_MIN;
      len_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      p_lat_q   <= p_lat_d;
      len_lat_q <= len_lat_d;
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;
  assign busy     = (state_q == S_RUN);

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed testbench for uart_rx_bit_timer.
// Each enabled cycle c of a frame is checked against edge = c mod p,
// bit = (c div p) mod L, and the strobe / pulse decodes derived from those.
module tb_uart_rx_bit_timer;

  localparam int unsigned PRESCALE_W = 6;

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [3:0]            data_bits;
  logic                  par_en;
  logic                  stop2;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  busy;
  logic                  sample_strb;
  logic [1:0]            sample_idx;
  logic                  bit_done;
  logic                  frame_done;

  int n_cmp;
  int n_bad;
  int fd_at;

  uart_rx_bit_timer #(
    .PRESCALE_W   (PRESCALE_W),
    .MAX_DATA_BITS(9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .data_bits  (data_bits),
    .par_en     (par_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .busy       (busy),
    .sample_strb(sample_strb),
    .sample_idx (sample_idx),
    .bit_done   (bit_done),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check all outputs for enabled cycle c of a frame with prescale p, length l
  task automatic expect_cycle(input string tag, input int c, input int p, input int l);
    int e, b, m, s, idx, bd, fd, bz;
    e   = c % p;
    b   = (c / p) % l;
    m   = p / 2;
    s   = (e == m - 1 || e == m || e == m + 1) ? 1 : 0;
    idx = (e == m) ? 1 : ((e == m + 1) ? 2 : 0);
    bd  = (e == p - 1) ? 1 : 0;
    fd  = (bd == 1 && b == l - 1) ? 1 : 0;
    bz  = (c % (l * p) == 0) ? 0 : 1;
    check($sformatf("%s c%0d edge_cnt", tag, c), 32'(edge_cnt), e);
    check($sformatf("%s c%0d bit_cnt", tag, c), 32'(bit_cnt), b);
    check($sformatf("%s c%0d busy", tag, c), 32'(busy), bz);
    check($sformatf("%s c%0d sample_strb", tag, c), 32'(sample_strb), s);
    check($sformatf("%s c%0d sample_idx", tag, c), 32'(sample_idx), idx);
    check($sformatf("%s c%0d bit_done", tag, c), 32'(bit_done), bd);
    check($sformatf("%s c%0d frame_done", tag, c), 32'(frame_done), fd);
    if (frame_done === 1'b1 && fd_at < 0) fd_at = c;
  endtask

  // Caller has just passed a negedge and driven inputs for cycle c0
  task automatic run_cycles(input string tag, input int c0, input int n, input int p, input int l);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      expect_cycle(tag, c0 + i, p, l);
    end
  endtask

  // Caller has just dropped enable at a negedge
  task automatic idle_check(input string tag);
    #1;
    check({tag, " gated sample_strb"}, 32'(sample_strb), 0);
    check({tag, " gated bit_done"}, 32'(bit_done), 0);
    check({tag, " gated frame_done"}, 32'(frame_done), 0);
    @(negedge clk);
    #1;
    check({tag, " idle edge_cnt"}, 32'(edge_cnt), 0);
    check({tag, " idle bit_cnt"}, 32'(bit_cnt), 0);
    check({tag, " idle busy"}, 32'(busy), 0);
    check({tag, " idle frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic do_frame(input string tag, input int pre, input int db, input int pe, input int s2,
                          input int p, input int l, input int n, input int fd_exp);
    @(negedge clk);
    prescale  = PRESCALE_W'(pre);
    data_bits = 4'(db);
    par_en    = 1'(pe);
    stop2     = 1'(s2);
    enable    = 1'b1;
    fd_at     = -1;
    run_cycles(tag, 0, n, p, l);
    if (fd_exp >= 0) check({tag, " frame_done cycle"}, 32'(fd_at), 32'(fd_exp));
    @(negedge clk);
    enable = 1'b0;
    idle_check(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " edge_cnt"}, 32'(edge_cnt), 0);
    check({tag, " bit_cnt"}, 32'(bit_cnt), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " sample_strb"}, 32'(sample_strb), 0);
    check({tag, " sample_idx"}, 32'(sample_idx), 0);
    check({tag, " bit_done"}, 32'(bit_done), 0);
    check({tag, " frame_done"}, 32'(frame_done), 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    fd_at     = -1;
    rst       = 1'b1;
    enable    = 1'b0;
    prescale  = PRESCALE_W'(8);
    data_bits = 4'd8;
    par_en    = 1'b0;
    stop2     = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // tag, prescale, data_bits, par_en, stop2, p, L, cycles, frame_done cycle
    do_frame("base",     8,  8, 0, 0,  8, 10,  81,  79);
    do_frame("max_fmt", 16,  9, 1, 1, 16, 13, 209, 207);
    do_frame("p_clamp",  2,  8, 0, 0,  4, 10,  41,  39);
    do_frame("d_hi",     4, 15, 0, 0,  4, 11,  45,  43);
    do_frame("d_lo",     4,  2, 0, 0,  4,  7,  29,  27);
    do_frame("odd_p",    5,  5, 0, 0,  5,  7,  36,  34);
    do_frame("max_p",   63,  5, 0, 0, 63,  7,  64,  -1);

    // Mid-frame config change is ignored; next frame picks it up back-to-back
    @(negedge clk);
    prescale  = PRESCALE_W'(8);
    data_bits = 4'd8;
    par_en    = 1'b0;
    stop2     = 1'b0;
    enable    = 1'b1;
    fd_at     = -1;
    run_cycles("midcfg", 0, 20, 8, 10);
    @(negedge clk);
    prescale  = PRESCALE_W'(12);
    data_bits = 4'd5;
    run_cycles("midcfg", 20, 61, 8, 10);
    check("midcfg frame_done cycle", 32'(fd_at), 79);

    // Second frame runs p=12, L=7; abort at cycle 30
    fd_at = -1;
    @(negedge clk);
    run_cycles("b2b", 1, 29, 12, 7);
    @(negedge clk);
    enable = 1'b0;
    idle_check("abort");
    check("abort no frame_done", 32'(fd_at), 32'(-1));

    // Async reset mid-frame at cycle 45
    @(negedge clk);
    prescale  = PRESCALE_W'(8);
    data_bits = 4'd8;
    enable    = 1'b1;
    run_cycles("pre_rst", 0, 45, 8, 10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    run_cycles("post_rst", 0, 20, 8, 10);
    @(negedge clk);
    enable = 1'b0;
    idle_check("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
